execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/cpu32_pkg.sv | 79 +++++++
 rtl/mul_seq.sv | 70 +++++++
 rtl/execute_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu32_pkg.sv
// Shared constants for the cpu32 datapath: opcodes, condition codes, flag
// bit positions, and the condition evaluator used by decode and execute.
package cpu32_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_ADC = 8'h03;
  localparam logic [7:0] OP_SBC = 8'h04;
  localparam logic [7:0] OP_AND = 8'h05;
  localparam logic [7:0] OP_OR  = 8'h06;
  localparam logic [7:0] OP_XOR = 8'h07;
  localparam logic [7:0] OP_NOT = 8'h08;
  localparam logic [7:0] OP_SHL = 8'h09;
  localparam logic [7:0] OP_SHR = 8'h0A;
  localparam logic [7:0] OP_SAR = 8'h0B;
  localparam logic [7:0] OP_MOV = 8'h0C;
  localparam logic [7:0] OP_CMP = 8'h0D;
  localparam logic [7:0] OP_MUL = 8'h10;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int MUL_CYCLES = 32;

  typedef enum logic {
    MS_IDLE,
    MS_RUN
  } mul_state_t;

  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, pass;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    pass = 1'b0;
    case (cc)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Unsigned 32x32 shift-add multiplier, one partial product per cycle.
//   state   | meaning
//   MS_IDLE | waiting for start
//   MS_RUN  | accumulating; done flags the final iteration
module mul_seq
  import cpu32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] p
);

  mul_state_t  state_q, state_d;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] acc_next;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : 64'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE: if (start) state_d = MS_RUN;
      MS_RUN:  if (cnt_q == 6'd1) state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (state_q == MS_IDLE) begin
      if (start) begin
        cnt_q    <= 6'(MUL_CYCLES);
        acc_q    <= '0;
        mcand_q  <= {32'd0, a};
        mplier_q <= b;
      end
    end else begin
      cnt_q    <= cnt_q - 6'd1;
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  assign busy = (state_q == MS_RUN);
  // The product is taken from the adder output so it is ready on the last edge.
  assign done = busy && (cnt_q == 6'd1);
  assign p    = acc_next;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU with conditional execution and masked NZCV
// update, plus a stalling iterative unsigned multiply.
module execute_stage
  import cpu32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] qe_a,
  input  logic [31:0] qe_b,
  input  logic [7:0]  qe_alu_op,
  input  logic        qe_is_cond,
  input  logic [3:0]  qe_cond,
  input  logic [3:0]  qe_write_flags,
  input  logic        qe_swp,
  output logic [31:0] x_res,
  output logic [31:0] x_res_hi,
  output logic        x_valid,
  output logic [3:0]  x_flags,
  output logic        x_stall
);

  logic [31:0] op_a, op_b, b_x;
  logic [4:0]  shamt;
  logic        is_sub, use_carry, cin;
  logic [32:0] sum33, shl33, shr33, sar33;
  logic signed [32:0] sar_in;
  logic        add_ovf;

  logic [31:0] alu_res;
  logic [3:0]  alu_flags;
  logic        wr_res, wr_flags, is_mul;
  logic        cond_ok, accept, mul_start;
  logic        mul_busy, mul_done;
  logic [63:0] mul_p;
  logic [3:0]  mul_mask_q;

  assign op_a  = qe_swp ? qe_b : qe_a;
  assign op_b  = qe_swp ? qe_a : qe_b;
  assign shamt = op_b[4:0];

  // One 33-bit adder serves ADD/ADC/SUB/SBC/CMP; subtraction is A + ~B + cin.
  assign is_sub    = (qe_alu_op == OP_SUB) || (qe_alu_op == OP_SBC) || (qe_alu_op == OP_CMP);
  assign use_carry = (qe_alu_op == OP_ADC) || (qe_alu_op == OP_SBC);
  assign cin       = use_carry ? x_flags[FLAG_C] : is_sub;
  assign b_x       = is_sub ? ~op_b : op_b;
  assign sum33     = {1'b0, op_a} + {1'b0, b_x} + {32'd0, cin};
  assign add_ovf   = (op_a[31] == b_x[31]) && (sum33[31] != op_a[31]);

  // Extra bit beyond the word catches the last bit shifted out.
  assign shl33  = {1'b0, op_a} << shamt;
  assign shr33  = {op_a, 1'b0} >> shamt;
  assign sar_in = {op_a, 1'b0};
  assign sar33  = sar_in >>> shamt;

  always_comb begin
    alu_res   = '0;
    alu_flags = x_flags;
    wr_res    = 1'b0;
    wr_flags  = 1'b0;
    is_mul    = 1'b0;
    case (qe_alu_op)
      OP_NOP: ;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
        alu_res           = sum33[31:0];
        alu_flags[FLAG_C] = sum33[32];
        alu_flags[FLAG_V] = add_ovf;
        wr_res            = (qe_alu_op != OP_CMP);
        wr_flags          = 1'b1;
      end
      OP_AND: begin alu_res = op_a & op_b; wr_res = 1'b1; wr_flags = 1'b1; end
      OP_OR:  begin alu_res = op_a | op_b; wr_res = 1'b1; wr_flags = 1'b1; end
      OP_XOR: begin alu_res = op_a ^ op_b; wr_res = 1'b1; wr_flags = 1'b1; end
      OP_NOT: begin alu_res = ~op_a;       wr_res = 1'b1; wr_flags = 1'b1; end
      OP_MOV: begin alu_res = op_b;        wr_res = 1'b1; wr_flags = 1'b1; end
      OP_SHL: begin
        alu_res = shl33[31:0];
        if (shamt != 5'd0) alu_flags[FLAG_C] = shl33[32];
        wr_res   = 1'b1;
        wr_flags = 1'b1;
      end
      OP_SHR: begin
        alu_res = shr33[32:1];
        if (shamt != 5'd0) alu_flags[FLAG_C] = shr33[0];
        wr_res   = 1'b1;
        wr_flags = 1'b1;
      end
      OP_SAR: begin
        alu_res = sar33[32:1];
        if (shamt != 5'd0) alu_flags[FLAG_C] = sar33[0];
        wr_res   = 1'b1;
        wr_flags = 1'b1;
      end
      OP_MUL: is_mul = 1'b1;
      default: ;
    endcase
    alu_flags[FLAG_N] = alu_res[31];
    alu_flags[FLAG_Z] = (alu_res == 32'd0);
  end

  assign cond_ok   = !qe_is_cond || cond_pass(qe_cond, x_flags);
  assign accept    = !x_stall && cond_ok;
  assign mul_start = accept && is_mul;

  mul_seq u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (op_a),
    .b     (op_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  assign x_stall = mul_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_res      <= '0;
      x_res_hi   <= '0;
      x_valid    <= 1'b0;
      x_flags    <= '0;
      mul_mask_q <= '0;
    end else begin
      x_valid <= 1'b0;
      if (mul_done) begin
        x_res    <= mul_p[31:0];
        x_res_hi <= mul_p[63:32];
        x_valid  <= 1'b1;
        // MUL only ever touches N and Z, under the mask captured at acceptance.
        x_flags  <= (x_flags & ~(mul_mask_q & 4'b1100)) |
                    ({mul_p[63], (mul_p == 64'd0), 2'b00} & mul_mask_q & 4'b1100);
      end else if (accept) begin
        if (wr_res) begin
          x_res    <= alu_res;
          x_res_hi <= '0;
          x_valid  <= 1'b1;
        end
        if (wr_flags) x_flags <= (x_flags & ~qe_write_flags) | (alu_flags & qe_write_flags);
        if (is_mul) mul_mask_q <= qe_write_flags;
      end
    end
  end

endmodule
